// File: rtl/port_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : port_bus_arbiter_if
// Brief   : Two-master / shared-peripheral bus bundle for port_bus_arbiter.
// Revision: 1.0
// ============================================================================
interface port_bus_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] port_id0;
  logic [7:0] port_id1;
  logic [7:0] out_port0;
  logic [7:0] out_port1;
  logic       write_strobe0;
  logic       write_strobe1;
  logic       read_strobe0;
  logic       read_strobe1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] in_port0;
  logic [7:0] in_port1;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       violation;
  logic       timeout;

  // Arbiter side
  modport slave (
    input  req0, req1, port_id0, port_id1, out_port0, out_port1,
    input  write_strobe0, write_strobe1, read_strobe0, read_strobe1,
    input  in_port,
    output gnt0, gnt1, in_port0, in_port1, port_id, out_port,
    output write_strobe, read_strobe, violation, timeout
  );

  // Masters and peripheral side
  modport master (
    output req0, req1, port_id0, port_id1, out_port0, out_port1,
    output write_strobe0, write_strobe1, read_strobe0, read_strobe1,
    output in_port,
    input  gnt0, gnt1, in_port0, in_port1, port_id, out_port,
    input  write_strobe, read_strobe, violation, timeout
  );
endinterface
`default_nettype wire

// File: rtl/port_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : port_bus_arbiter
// Brief   : Round-robin arbiter giving two masters access to one peripheral
//           port bus. Optional hold-limit revocation via `ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module port_bus_arbiter #(
  parameter int MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  port_bus_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNT0 = 2'd1;
  localparam logic [1:0] S_GNT1 = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
    $error("port_bus_arbiter: MAX_HOLD must be in 2..255");
  end

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       r_ptr;
  logic       w_next_ptr;
  logic       r_violation;
  logic       w_strobe_violation;
  logic       w_timeout_revoke;
  logic       w_hold_limit;
  logic       w_gnt0;
  logic       w_gnt1;

  // r_ptr = 1 means master 1 wins a simultaneous request
  function automatic logic [1:0] arbitrate(input logic r0, input logic r1, input logic ptr);
    if (r0 && r1)  return ptr ? S_GNT1 : S_GNT0;
    else if (r0)   return S_GNT0;
    else if (r1)   return S_GNT1;
    else           return S_IDLE;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] c_HOLD_LIMIT = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;
  logic       r_timeout;

  assign w_hold_limit = (r_hold_cnt == c_HOLD_LIMIT);

  // Counter is zero on the first cycle of every grant and saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout_revoke;
      if (r_state == S_IDLE || r_state == S_TURN)
        r_hold_cnt <= 8'd0;
      else if (!w_hold_limit)
        r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_hold_limit = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_violation <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ptr       <= w_next_ptr;
      r_violation <= r_violation | w_strobe_violation;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_ptr       = r_ptr;
    w_timeout_revoke = 1'b0;
    case (r_state)
      S_IDLE, S_TURN: begin
        w_next_state = arbitrate(bus.req0, bus.req1, r_ptr);
      end
      S_GNT0: begin
        if (!bus.req0) begin
          w_next_state = S_TURN;
          w_next_ptr   = 1'b1;
        end else if (w_hold_limit && bus.req1) begin
          w_next_state     = S_TURN;
          w_next_ptr       = 1'b1;
          w_timeout_revoke = 1'b1;
        end
      end
      S_GNT1: begin
        if (!bus.req1) begin
          w_next_state = S_TURN;
          w_next_ptr   = 1'b0;
        end else if (w_hold_limit && bus.req0) begin
          w_next_state     = S_TURN;
          w_next_ptr       = 1'b0;
          w_timeout_revoke = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt0           = (r_state == S_GNT0);
    w_gnt1           = (r_state == S_GNT1);
    bus.gnt0         = w_gnt0;
    bus.gnt1         = w_gnt1;
    bus.port_id      = 8'h00;
    bus.out_port     = 8'h00;
    bus.write_strobe = 1'b0;
    bus.read_strobe  = 1'b0;
    bus.in_port0     = 8'h00;
    bus.in_port1     = 8'h00;
    if (w_gnt0) begin
      bus.port_id      = bus.port_id0;
      bus.out_port     = bus.out_port0;
      bus.write_strobe = bus.write_strobe0;
      bus.read_strobe  = bus.read_strobe0;
      bus.in_port0     = bus.in_port;
    end else if (w_gnt1) begin
      bus.port_id      = bus.port_id1;
      bus.out_port     = bus.out_port1;
      bus.write_strobe = bus.write_strobe1;
      bus.read_strobe  = bus.read_strobe1;
      bus.in_port1     = bus.in_port;
    end
    w_strobe_violation = ((bus.write_strobe0 | bus.read_strobe0) & ~w_gnt0) |
                         ((bus.write_strobe1 | bus.read_strobe1) & ~w_gnt1);
  end

  assign bus.violation = r_violation;

endmodule
`default_nettype wire

// File: tb/tb_port_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_port_bus_arbiter
// Brief   : Directed vector table plus multi-cycle sequences for port_bus_arbiter.
// Revision: 1.0
// ============================================================================
module tb_port_bus_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  port_bus_arbiter_if bus();

  port_bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req0;
    logic        req1;
    logic [7:0]  pid0;
    logic [7:0]  op0;
    logic        ws0;
    logic        rs0;
    logic [7:0]  pid1;
    logic [7:0]  op1;
    logic        ws1;
    logic        rs1;
    logic [7:0]  inp;
    logic [37:0] exp_out;
  } vec_t;

  vec_t vecs [15];

  // Expected: {gnt0, gnt1, port_id, out_port, write_strobe, read_strobe, in_port0, in_port1, violation, timeout}
  function automatic vec_t mk(input logic r0, input logic r1, input logic [7:0] p0, input logic [7:0] o0,
                              input logic w0, input logic s0, input logic [7:0] p1, input logic [7:0] o1,
                              input logic w1, input logic s1, input logic [7:0] ip,
                              input logic g0, input logic g1, input logic [7:0] ep, input logic [7:0] eo,
                              input logic ew, input logic er, input logic [7:0] ei0, input logic [7:0] ei1,
                              input logic ev, input logic et);
    vec_t v;
    v.req0 = r0;  v.req1 = r1;
    v.pid0 = p0;  v.op0  = o0;  v.ws0 = w0;  v.rs0 = s0;
    v.pid1 = p1;  v.op1  = o1;  v.ws1 = w1;  v.rs1 = s1;
    v.inp  = ip;
    v.exp_out = {g0, g1, ep, eo, ew, er, ei0, ei1, ev, et};
    return v;
  endfunction

  function automatic logic [37:0] observed();
    return {bus.gnt0, bus.gnt1, bus.port_id, bus.out_port, bus.write_strobe,
            bus.read_strobe, bus.in_port0, bus.in_port1, bus.violation, bus.timeout};
  endfunction

  task automatic apply(input vec_t v);
    bus.req0 = v.req0;  bus.req1 = v.req1;
    bus.port_id0 = v.pid0;  bus.out_port0 = v.op0;
    bus.write_strobe0 = v.ws0;  bus.read_strobe0 = v.rs0;
    bus.port_id1 = v.pid1;  bus.out_port1 = v.op1;
    bus.write_strobe1 = v.ws1;  bus.read_strobe1 = v.rs1;
    bus.in_port = v.inp;
  endtask

  task automatic quiet();
    apply(mk(0,0, 8'h00,8'h00,0,0, 8'h00,8'h00,0,0, 8'h00, 0,0,8'h00,8'h00,0,0,8'h00,8'h00,0,0));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    quiet();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] seq_g0, seq_g1, seq_to;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    quiet();

    //                r0 r1 pid0   op0   w0 s0 pid1   op1   w1 s1 inp      g0 g1 port   out   ws rs ip0    ip1   vi to
    vecs[0]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h11,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    vecs[1]  = mk(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h11,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    vecs[2]  = mk(1, 0, 8'h30, 8'h5A, 1, 0, 8'h77, 8'h66, 0, 0, 8'h3C,   1, 0, 8'h30, 8'h5A, 1, 0, 8'h3C, 8'h00, 0, 0);
    vecs[3]  = mk(1, 1, 8'h31, 8'h00, 0, 1, 8'h20, 8'h99, 0, 0, 8'h3C,   1, 0, 8'h31, 8'h00, 0, 1, 8'h3C, 8'h00, 0, 0);
    vecs[4]  = mk(0, 1, 8'h12, 8'h34, 0, 0, 8'h20, 8'h99, 0, 0, 8'h44,   1, 0, 8'h12, 8'h34, 0, 0, 8'h44, 8'h00, 0, 0);
    vecs[5]  = mk(0, 1, 8'h00, 8'h00, 0, 0, 8'h20, 8'hC3, 0, 0, 8'h55,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    vecs[6]  = mk(0, 1, 8'h00, 8'h00, 0, 0, 8'h20, 8'hC3, 1, 0, 8'hA5,   0, 1, 8'h20, 8'hC3, 1, 0, 8'h00, 8'hA5, 0, 0);
    vecs[7]  = mk(1, 1, 8'h30, 8'h11, 0, 0, 8'h31, 8'h00, 0, 1, 8'h5E,   0, 1, 8'h31, 8'h00, 0, 1, 8'h00, 8'h5E, 0, 0);
    vecs[8]  = mk(1, 0, 8'h30, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 8'h5E,   0, 1, 8'h00, 8'h00, 0, 0, 8'h00, 8'h5E, 0, 0);
    vecs[9]  = mk(1, 0, 8'h30, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 8'h5E,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    vecs[10] = mk(1, 0, 8'h30, 8'h11, 0, 0, 8'h31, 8'h00, 0, 1, 8'h66,   1, 0, 8'h30, 8'h11, 0, 0, 8'h66, 8'h00, 0, 0);
    vecs[11] = mk(1, 0, 8'h30, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 8'h66,   1, 0, 8'h30, 8'h11, 0, 0, 8'h66, 8'h00, 1, 0);
    vecs[12] = mk(0, 0, 8'h30, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 8'h66,   1, 0, 8'h30, 8'h11, 0, 0, 8'h66, 8'h00, 1, 0);
    vecs[13] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h66,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
    vecs[14] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h66,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);

    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 64'(observed()), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), 64'(observed()), 64'(vecs[i].exp_out));
    end

    // Pointer now favours master 1 (last grant was master 0)
    @(negedge clk);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clk); #1;
    check("ptr_gnt1", 64'({bus.gnt0, bus.gnt1}), 64'b01);
    bus.req1 = 1'b0;
    @(negedge clk); #1;
    check("turn_after_gnt1", 64'({bus.gnt0, bus.gnt1}), 64'b00);
    bus.req1 = 1'b1;
    @(negedge clk); #1;
    check("reraise_in_turn_gnt0", 64'({bus.gnt0, bus.gnt1}), 64'b10);
    quiet();
    repeat (2) @(negedge clk);

    // Asynchronous reset during a master-1 grant
    do_reset();
    @(negedge clk);
    bus.req1 = 1'b1; bus.port_id1 = 8'h30; bus.write_strobe1 = 1'b1;
    @(negedge clk); #1;
    check("gnt1_before_reset", 64'({bus.gnt1, bus.write_strobe, bus.port_id}), 64'({1'b1, 1'b1, 8'h30}));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", 64'({bus.gnt0, bus.gnt1, bus.write_strobe, bus.port_id}), 64'd0);
    @(negedge clk);
    quiet();
    bus.req0 = 1'b1;
    rst_n = 1'b1;
    #1;
    check("release_no_gnt_yet", 64'({bus.gnt0, bus.gnt1}), 64'b00);
    @(negedge clk); #1;
    check("gnt0_after_release", 64'({bus.gnt0, bus.gnt1}), 64'b10);

    // Hold limit behaviour with MAX_HOLD = 4
    do_reset();
    @(negedge clk);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    seq_g0 = '0; seq_g1 = '0; seq_to = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); #1;
      seq_g0[k] = bus.gnt0; seq_g1[k] = bus.gnt1; seq_to[k] = bus.timeout;
    end
`ifdef ARB_TIMEOUT_EN
    check("hold_gnt0_seq", 64'(seq_g0), 64'h000F);
    check("hold_gnt1_seq", 64'(seq_g1), 64'h0060);
    check("hold_timeout_seq", 64'(seq_to), 64'h0010);
`else
    check("nolimit_gnt0_seq", 64'(seq_g0), 64'h007F);
    check("nolimit_gnt1_seq", 64'(seq_g1), 64'h0000);
    check("nolimit_timeout_seq", 64'(seq_to), 64'h0000);
`endif

    // Lone requester keeps the bus past the limit; a late rival then revokes it
    do_reset();
    @(negedge clk);
    bus.req0 = 1'b1;
    seq_g0 = '0; seq_g1 = '0; seq_to = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      seq_g0[k] = bus.gnt0; seq_g1[k] = bus.gnt1; seq_to[k] = bus.timeout;
      if (k == 7) bus.req1 = 1'b1;
    end
`ifdef ARB_TIMEOUT_EN
    check("sat_gnt0_seq", 64'(seq_g0), 64'h00FF);
    check("sat_gnt1_seq", 64'(seq_g1), 64'h0200);
    check("sat_timeout_seq", 64'(seq_to), 64'h0100);
`else
    check("lone_gnt0_seq", 64'(seq_g0), 64'h03FF);
    check("lone_gnt1_seq", 64'(seq_g1), 64'h0000);
    check("lone_timeout_seq", 64'(seq_to), 64'h0000);
`endif

    quiet();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
